pipe_fetch_queue: RTL and testbench
===================================

Name: pipe_fetch_queue

Overview:
- Parametrised successor to the single-entry IF/ID pipeline register: a DEPTH-entry FIFO of (pc4, inst) pairs between the IF stage and the ID stage.
- Lets IF keep fetching while ID is stalled by the load-use interlock.
- Supports a single-cycle flush when a branch or jump redirects the PC.
- Presents a NOP bubble (all-zero instruction) to ID whenever it is empty.

Parameters:
- DATA_W, 32, instruction word width
- PC_W, 32, width of the stored pc4 value
- DEPTH, 4, number of entries; power of two, minimum 2
- CNT_W, $clog2(DEPTH)+1, width of the occupancy count

Ports:
- clock  input  1  system clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-high reset
- flush  input  1  discard all entries (taken branch/jump from ID)
- in_valid  input  1  IF presents a fetched instruction
- in_pc4  input  PC_W  pc+4 of the fetched instruction
- in_inst  input  DATA_W  fetched instruction word
- in_ready  output  1  queue can accept an entry this cycle
- out_valid  output  1  head entry valid for ID
- out_pc4  output  PC_W  pc+4 of the head entry
- out_inst  output  DATA_W  head instruction; 0 (NOP) when out_valid=0
- out_ready  input  1  ID consumes the head this cycle (the ~stall signal)
- count  output  CNT_W  current occupancy, 0..DEPTH
- overflow  output  1  sticky flag: push attempted while full

Behaviour:
- Reset (asynchronous, active-high):
  - rd_ptr=0, wr_ptr=0, count=0, overflow=0.
  - in_ready=1, out_valid=0, out_pc4=0, out_inst=0.
  - Storage contents are don't-care.
- Combinational outputs:
  - in_ready = (count != DEPTH). It does not depend on out_ready, so there is no ready pass-through.
  - out_valid = (count != 0).
  - out_pc4 and out_inst = mem[rd_ptr] when out_valid=1, otherwise 0.
- push = in_valid & in_ready. pop = out_valid & out_ready.
- On each rising edge, evaluated in priority order:
  1. flush=1: rd_ptr=wr_ptr=0, count=0. Any push or pop in the same cycle is discarded. overflow is unchanged.
  2. push only: mem[wr_ptr] <= {in_pc4, in_inst}; wr_ptr+1; count+1.
  3. pop only: rd_ptr+1; count-1.
  4. push and pop together: write and advance both pointers; count unchanged. Legal at any occupancy where in_ready=1.
  5. in_valid=1 while full (in_ready=0): no write; overflow <= 1. overflow stays sticky until reset.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH with no special case.
- Latency: an entry pushed at edge N is visible on out_* after edge N; there is no same-cycle bypass when empty.
- Ordering is strict FIFO: entries leave in push order, and pc4/inst pairs are never split.
- count is registered and never exceeds DEPTH or goes below 0.
- out_ready while empty has no effect.
- flush while empty is a no-op apart from resetting the pointers to 0.
- Reset asserted mid-operation returns to the reset state immediately, without waiting for a clock edge.
- Deassertion of reset is synchronous to the design.
- Downstream, ID stays equivalent to the single-register design: with DEPTH entries and out_ready tied to ~stall, a stalled ID holds the same head entry until out_ready=1.

Test Plan:
- Reset then idle:
  - Stimulus: reset=1, then deassert.
  - Required: count=0, in_ready=1, out_valid=0, out_inst=0x00000000, overflow=0.
- Fill to full:
  - Stimulus: out_ready=0; push four entries with pc4=0x4,0x8,0xC,0x10 and inst=0x20080001..0x20080004.
  - Required: count=4, in_ready=0, head out_pc4=0x4, out_inst=0x20080001.
  - Stimulus: a fifth push while full.
  - Required: overflow=1; entries unchanged.
- Drain in order:
  - Stimulus: from full, out_ready=1 and in_valid=0 for four cycles.
  - Required: out_inst sequence 0x20080001, 0x20080002, 0x20080003, 0x20080004; then out_valid=0, out_inst=0, count=0.
- Simultaneous push and pop with wrap:
  - Stimulus: DEPTH=4, count=2; in_valid=1 and out_ready=1 for 8 cycles with incrementing pc4.
  - Required: count stays 2; both pointers wrap past 3 to 0; outputs appear in the same order as pushed.
- Flush priority:
  - Stimulus: count=3; in the same cycle assert flush=1, in_valid=1, out_ready=1.
  - Required: next cycle count=0, out_valid=0, out_inst=0; the pushed entry is absent.
  - Stimulus: one subsequent push with pc4=0x40.
  - Required: out_pc4=0x40 after one edge.
- Asynchronous reset mid-stream:
  - Stimulus: count=3, overflow=1; assert reset between clock edges.
  - Required: count=0, overflow=0, out_valid=0 before the next rising edge.

Source files
------------

// File: rtl/pipe_fetch_queue_if.sv
// Handshake bundle between the IF stage and the ID stage around the fetch
// queue. The master side is the environment (IF producer plus ID consumer);
// the slave side is the queue itself.
interface pipe_fetch_queue_if #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DEPTH) + 1
);
    logic              flush;
    logic              in_valid;
    logic [PC_W-1:0]   in_pc4;
    logic [DATA_W-1:0] in_inst;
    logic              in_ready;
    logic              out_valid;
    logic [PC_W-1:0]   out_pc4;
    logic [DATA_W-1:0] out_inst;
    logic              out_ready;
    logic [CNT_W-1:0]  count;
    logic              overflow;

    modport master (
        output flush, in_valid, in_pc4, in_inst, out_ready,
        input  in_ready, out_valid, out_pc4, out_inst, count, overflow
    );

    modport slave (
        input  flush, in_valid, in_pc4, in_inst, out_ready,
        output in_ready, out_valid, out_pc4, out_inst, count, overflow
    );
endinterface

// File: rtl/pipe_fetch_queue.sv
// DEPTH-entry FIFO of (pc4, inst) pairs between IF and ID. IF keeps fetching
// while ID is stalled; a flush empties the queue in one cycle on a redirect,
// and an empty queue presents an all-zero NOP bubble to ID.
module pipe_fetch_queue #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic                 clock,
    input  logic                 reset,
    pipe_fetch_queue_if.slave    bus
);
    localparam int              PTR_W     = $clog2(DEPTH);
    localparam int              ENTRY_W   = PC_W + DATA_W;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ZERO  = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

    logic [ENTRY_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [CNT_W-1:0]   count_r;
    logic               overflow_r;

    logic               in_ready_s;
    logic               out_valid_s;
    logic               push_s;
    logic               pop_s;
    logic               ovf_hit_s;
    logic [ENTRY_W-1:0] head_s;

    // Handshake decode and NOP-bubble head selection; in_ready never looks at out_ready.
    always_comb begin
        in_ready_s  = (count_r != DEPTH_CNT);
        out_valid_s = (count_r != CNT_ZERO);
        push_s      = bus.in_valid & in_ready_s;
        pop_s       = out_valid_s & bus.out_ready;
        ovf_hit_s   = ~bus.flush & bus.in_valid & ~in_ready_s;
        if (out_valid_s) begin
            head_s = mem_r[rd_ptr_r];
        end else begin
            head_s = {ENTRY_W{1'b0}};
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_s;
    assign bus.out_pc4   = head_s[ENTRY_W-1:DATA_W];
    assign bus.out_inst  = head_s[DATA_W-1:0];
    assign bus.count     = count_r;
    assign bus.overflow  = overflow_r;

    // Pointer and occupancy update; flush dominates any same-cycle push or pop.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr_r <= PTR_ZERO;
            wr_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
        end else if (bus.flush) begin
            rd_ptr_r <= PTR_ZERO;
            wr_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            if (push_s && !pop_s) begin
                count_r <= count_r + CNT_ONE;
            end else if (pop_s && !push_s) begin
                count_r <= count_r - CNT_ONE;
            end else begin
                count_r <= count_r;
            end
        end
    end

    // Sticky overflow: a push attempted while full, cleared only by reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            overflow_r <= 1'b0;
        end else if (ovf_hit_s) begin
            overflow_r <= 1'b1;
        end else begin
            overflow_r <= overflow_r;
        end
    end

    // Entry storage; contents are don't-care after reset so no reset term.
    always_ff @(posedge clock) begin
        if (push_s && !bus.flush) begin
            mem_r[wr_ptr_r] <= {bus.in_pc4, bus.in_inst};
        end
    end
endmodule

// File: tb/tb_pipe_fetch_queue.sv
// Self-checking bench for pipe_fetch_queue: directed scenarios followed by
// randomized traffic. The stimulus process keeps a reference queue of pushed
// (pc4, inst) pairs; a separate monitor compares the DUT against it on every
// falling edge and retires the head entry when ID consumes it.
module tb_pipe_fetch_queue;
    localparam int DATA_W = 32;
    localparam int PC_W   = 32;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    logic clock;
    logic reset;

    pipe_fetch_queue_if #(.DATA_W(DATA_W), .PC_W(PC_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

    pipe_fetch_queue #(.DATA_W(DATA_W), .PC_W(PC_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Reference model state
    logic [63:0] sb_q[$];
    logic        model_ovf;
    bit          mon_en;

    int vectors;
    int miscompares;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Monitor: compare on the falling edge, retire the head when ID consumes it.
    initial begin
        forever begin
            @(negedge clock);
            if (mon_en && !reset) begin
                chk("count", 64'(bus.count), 64'(sb_q.size()));
                chk("in_ready", 64'(bus.in_ready), 64'(sb_q.size() != DEPTH));
                chk("out_valid", 64'(bus.out_valid), 64'(sb_q.size() != 0));
                chk("overflow", 64'(bus.overflow), 64'(model_ovf));
                if (sb_q.size() != 0) begin
                    chk("head_pc4", 64'(bus.out_pc4), 64'(sb_q[0][63:32]));
                    chk("head_inst", 64'(bus.out_inst), 64'(sb_q[0][31:0]));
                    if (bus.out_ready && !bus.flush) begin
                        void'(sb_q.pop_front());
                    end
                end else begin
                    chk("bubble_pc4", 64'(bus.out_pc4), 64'd0);
                    chk("bubble_inst", 64'(bus.out_inst), 64'd0);
                end
            end
        end
    end

    // Apply one cycle of inputs, then fold the edge into the reference model.
    task automatic drive(input logic f, input logic v, input logic r,
                         input logic [PC_W-1:0] pc, input logic [DATA_W-1:0] inst);
        bit accept;
        bit ovf_set;
        bus.flush     = f;
        bus.in_valid  = v;
        bus.out_ready = r;
        bus.in_pc4    = pc;
        bus.in_inst   = inst;
        accept  = v && (sb_q.size() < DEPTH);
        ovf_set = v && !f && (sb_q.size() == DEPTH);
        @(posedge clock);
        #1;
        if (f) begin
            sb_q.delete();
        end else if (accept) begin
            sb_q.push_back({pc, inst});
        end
        if (ovf_set) begin
            model_ovf = 1'b1;
        end
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        model_ovf   = 1'b0;
        mon_en      = 1'b0;
        reset       = 1'b1;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.in_pc4    = 32'h0;
        bus.in_inst   = 32'h0;
        repeat (2) @(posedge clock);
        #2;
        reset  = 1'b0;
        mon_en = 1'b1;

        // Reset then idle
        idle();
        idle();

        // Fill to full with ID stalled
        for (int i = 1; i <= 4; i++) begin
            drive(1'b0, 1'b1, 1'b0, 32'(4 * i), 32'h20080000 + 32'(i));
        end
        // Fifth push while full raises overflow, entries untouched
        drive(1'b0, 1'b1, 1'b0, 32'h14, 32'h20080005);
        idle();

        // Drain in order
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
        end
        idle();

        // Simultaneous push and pop with pointer wrap at count=2
        drive(1'b0, 1'b1, 1'b0, 32'h100, 32'hA0000000);
        drive(1'b0, 1'b1, 1'b0, 32'h104, 32'hA0000001);
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b1, 1'b1, 32'h108 + 32'(4 * i), 32'hA0000002 + 32'(i));
        end
        idle();

        // Flush priority at count=3 with push and pop in the same cycle
        drive(1'b0, 1'b1, 1'b0, 32'h200, 32'hB0000000);
        drive(1'b0, 1'b1, 1'b1, 32'h204, 32'hB0000001);
        drive(1'b1, 1'b1, 1'b1, 32'h208, 32'hB0000002);
        drive(1'b0, 1'b1, 1'b0, 32'h40, 32'hC0000000);
        idle();

        // Asynchronous reset mid-stream at count=3 with overflow set
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b0, 32'h300 + 32'(4 * i), 32'hD0000000 + 32'(i));
        end
        drive(1'b0, 1'b1, 1'b0, 32'h30C, 32'hD0000003);
        drive(1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
        #2;
        reset = 1'b1;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        chk("async_count", 64'(bus.count), 64'd0);
        chk("async_overflow", 64'(bus.overflow), 64'd0);
        chk("async_out_valid", 64'(bus.out_valid), 64'd0);
        chk("async_out_inst", 64'(bus.out_inst), 64'd0);
        sb_q.delete();
        model_ovf = 1'b0;
        @(posedge clock);
        #2;
        reset = 1'b0;
        idle();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 99) < 5) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 99) < 50) ? 1'b1 : 1'b0,
                  32'($urandom), 32'($urandom));
        end
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
        end

        @(negedge clock);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
